io_bus_master: RTL and testbench

//  CPU-side initiator for the memory-mapped IO bus (LED, 7-seg, switch, data RAM).

---
 rtl/io_bus_master_if.sv | 38 +++
 rtl/io_bus_master.sv | 135 +++++++++++++
 tb/tb_io_bus_master.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_master_if.sv
// io_bus_master_if: CPU request/response and IO bus signals of io_bus_master.
// master = initiator view (CPU inputs in, bus cycle out); slave = CPU + bus decoder.
interface io_bus_master_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [1:0]        cpu_size;
  logic              cpu_sext;
  logic [31:0]       cpu_wdata;
  logic              cpu_busy;
  logic              cpu_done;
  logic              cpu_err;
  logic [31:0]       cpu_rdata;
  logic [ADDR_W-3:0] bus_adr;
  logic              bus_we;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_spo;

  modport master (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_size, cpu_sext, cpu_wdata,
    output cpu_busy, cpu_done, cpu_err,
    output cpu_rdata,
    output bus_adr, bus_we, bus_wdata,
    input  bus_spo
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_size, cpu_sext, cpu_wdata,
    input  cpu_busy, cpu_done, cpu_err,
    input  cpu_rdata,
    input  bus_adr, bus_we, bus_wdata,
    output bus_spo
  );
endinterface

// File: rtl/io_bus_master.sv
// io_bus_master: turns one CPU load/store into word-wide IO bus cycles.
// Ports: clk, rst (sync, active-high), bus (io_bus_master_if.master).
// Macro IO_BUS_MASTER_SUBWORD_EN enables byte/half loads and RMW stores;
// without it only word accesses are accepted, others return cpu_err.
module io_bus_master #(
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  io_bus_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state;
  logic              r_we;
  logic [ADDR_W-3:0] r_adr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       rdata;
  logic              bad;
  logic [31:0]       ld_val;
  logic [31:0]       wr_word;

`ifdef IO_BUS_MASTER_SUBWORD_EN
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [31:0] rd_word;
  logic [31:0] sh;

  always_comb begin
    bad = 1'b0;
    unique case (bus.cpu_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = bus.cpu_addr[0];
      2'b10:   bad = |bus.cpu_addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  // Lane data right-aligned; legal halves have lane bit 0 clear.
  assign sh = bus.bus_spo >> {r_lane, 3'b000};

  always_comb begin
    ld_val = bus.bus_spo;
    unique case (r_size)
      2'b00:   ld_val = {{24{r_sext & sh[7]}}, sh[7:0]};
      2'b01:   ld_val = {{16{r_sext & sh[15]}}, sh[15:0]};
      default: ld_val = bus.bus_spo;
    endcase
  end

  always_comb begin
    wr_word = rd_word;
    unique case (r_size)
      2'b00:   wr_word[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   wr_word[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: wr_word = r_wdata;
    endcase
  end
`else
  logic unused_sext;

  assign unused_sext = bus.cpu_sext;
  assign bad    = (bus.cpu_size != 2'b10) | (|bus.cpu_addr[1:0]);
  assign ld_val = bus.bus_spo;
  assign wr_word = r_wdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      rdata   <= '0;
`ifdef IO_BUS_MASTER_SUBWORD_EN
      r_lane  <= '0;
      r_size  <= '0;
      r_sext  <= 1'b0;
      rd_word <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cpu_req) begin
            r_we    <= bus.cpu_we;
            r_adr   <= bus.cpu_addr[ADDR_W-1:2];
            r_wdata <= bus.cpu_wdata;
            r_err   <= bad;
`ifdef IO_BUS_MASTER_SUBWORD_EN
            r_lane  <= bus.cpu_addr[1:0];
            r_size  <= bus.cpu_size;
            r_sext  <= bus.cpu_sext;
`endif
            if (bad)
              state <= S_RESP;
            else if (bus.cpu_we && bus.cpu_size == 2'b10)
              state <= S_WR;
            else
              state <= S_RD;
          end
        end
        S_RD: begin
`ifdef IO_BUS_MASTER_SUBWORD_EN
          rd_word <= bus.bus_spo;
`endif
          if (r_we) begin
            state <= S_WR;
          end else begin
            rdata <= ld_val;
            state <= S_RESP;
          end
        end
        S_WR:    state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A write landing in a reset cycle must not reach the bus.
  assign bus.bus_we    = (state == S_WR) & ~rst;
  assign bus.bus_wdata = bus.bus_we ? wr_word : '0;
  assign bus.bus_adr   = r_adr;
  assign bus.cpu_busy  = (state != S_IDLE);
  assign bus.cpu_done  = (state == S_RESP);
  assign bus.cpu_err   = (state == S_RESP) & r_err;
  assign bus.cpu_rdata = rdata;

endmodule

// File: tb/tb_io_bus_master.sv
// tb_io_bus_master: randomized + directed bench for io_bus_master.
// A word-array memory acts as the bus slave; a separate model predicts results.
module tb_io_bus_master;

  localparam int AW = 16;
`ifdef IO_BUS_MASTER_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_bus_master_if #(.ADDR_W(AW)) bif ();

  io_bus_master #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] ref_rdata;
  int n_tests;
  int n_fail;

  assign bif.bus_spo = mem[bif.bus_adr];

  always @(posedge clk)
    if (bif.bus_we) mem[bif.bus_adr] <= bif.bus_wdata;

  task automatic poke(input logic [15:0] a, input logic [31:0] v);
    mem[a[15:2]] = v;
    ref_mem[a[15:2]] = v;
  endtask

  task automatic run(input logic we, input logic [15:0] addr,
                     input logic [1:0] size, input logic sext,
                     input logic [31:0] wdata, input string tag);
    logic        legal;
    int          exp_cyc;
    logic [31:0] w;
    logic [31:0] v;
    int          lane;
    int          idx;
    int          cyc;
    int          writes;
    logic        done;
    logic        got_err;
    logic [31:0] got_rd;
    logic [31:0] got_wd;
    logic        adr_bad;
    logic        wd_bad;
    idx = int'(addr[15:2]);
    lane = int'(addr[1:0]);
    if (size == 2'd3) legal = 1'b0;
    else if (size == 2'd2) legal = (addr % 4 == 0);
    else if (!SUB) legal = 1'b0;
    else if (size == 2'd1) legal = (addr % 2 == 0);
    else legal = 1'b1;
    if (!legal) exp_cyc = 1;
    else if (we && size != 2'd2) exp_cyc = 3;
    else exp_cyc = 2;
    w = ref_mem[idx];
    if (legal && we) begin
      if (size == 2'd2) w = wdata;
      else if (size == 2'd1) w[8*lane +: 16] = wdata[15:0];
      else w[8*lane +: 8] = wdata[7:0];
      ref_mem[idx] = w;
    end else if (legal) begin
      v = w >> (8 * lane);
      if (size == 2'd0)
        v = (sext && v[7]) ? {24'hFF_FFFF, v[7:0]} : {24'h0, v[7:0]};
      else if (size == 2'd1)
        v = (sext && v[15]) ? {16'hFFFF, v[15:0]} : {16'h0, v[15:0]};
      ref_rdata = v;
    end
    @(negedge clk);
    for (int k = 0; k < 20 && bif.cpu_busy; k++) @(negedge clk);
    n_tests++;
    if (bif.cpu_busy) begin
      n_fail++;
      $display("FAIL %s idle: busy=%b required 0", tag, bif.cpu_busy);
    end
    bif.cpu_req = 1'b1;
    bif.cpu_we = we;
    bif.cpu_addr = addr;
    bif.cpu_size = size;
    bif.cpu_sext = sext;
    bif.cpu_wdata = wdata;
    cyc = 0;
    writes = 0;
    done = 1'b0;
    got_err = 1'b0;
    got_rd = '0;
    got_wd = '0;
    adr_bad = 1'b0;
    wd_bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bif.bus_we) begin
        writes++;
        got_wd = bif.bus_wdata;
      end else if (bif.bus_wdata !== 32'h0) begin
        wd_bad = 1'b1;
      end
      if (bif.bus_adr !== addr[15:2]) adr_bad = 1'b1;
      if (bif.cpu_done) begin
        done = 1'b1;
        got_err = bif.cpu_err;
        got_rd = bif.cpu_rdata;
        break;
      end
    end
    bif.cpu_req = 1'b0;
    n_tests++;
    if (!done || cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s latency: done=%b cycles=%0d required %0d",
               tag, done, cyc, exp_cyc);
    end
    n_tests++;
    if (got_err !== !legal) begin
      n_fail++;
      $display("FAIL %s err: got %b required %b", tag, got_err, !legal);
    end
    n_tests++;
    if (writes != ((legal && we) ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s writes: got %0d required %0d",
               tag, writes, (legal && we) ? 1 : 0);
    end
    if (legal && we) begin
      n_tests++;
      if (got_wd !== w) begin
        n_fail++;
        $display("FAIL %s wdata: got %h required %h", tag, got_wd, w);
      end
    end
    n_tests++;
    if (got_rd !== ref_rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h required %h", tag, got_rd, ref_rdata);
    end
    n_tests++;
    if (adr_bad || wd_bad) begin
      n_fail++;
      $display("FAIL %s bus: adr_bad=%b wdata_bad=%b required 0 0",
               tag, adr_bad, wd_bad);
    end
    @(negedge clk);
    n_tests++;
    if (mem[idx] !== ref_mem[idx]) begin
      n_fail++;
      $display("FAIL %s mem[%0d]: got %h required %h",
               tag, idx, mem[idx], ref_mem[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.cpu_req = 1'b0;
    bif.cpu_we = 1'b0;
    bif.cpu_addr = '0;
    bif.cpu_size = 2'd2;
    bif.cpu_sext = 1'b0;
    bif.cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bif.cpu_busy, bif.cpu_done, bif.cpu_err, bif.bus_we} !== 4'b0 ||
        bif.cpu_rdata !== 32'h0 || bif.bus_wdata !== 32'h0 ||
        bif.bus_adr !== 14'h0) begin
      n_fail++;
      $display("FAIL reset: busy/done/err/we=%b%b%b%b rdata=%h wdata=%h adr=%h required all 0",
               bif.cpu_busy, bif.cpu_done, bif.cpu_err, bif.bus_we,
               bif.cpu_rdata, bif.bus_wdata, bif.bus_adr);
    end
    rst = 1'b0;
    ref_rdata = '0;
  endtask

  task automatic test_directed();
    run(1'b1, 16'hF060, 2'd2, 1'b0, 32'h0000_00A5, "word_store");
    n_tests++;
    if (mem[16'hF060 >> 2] !== 32'h0000_00A5) begin
      n_fail++;
      $display("FAIL word_store_mem: got %h required 000000a5", mem[16'hF060 >> 2]);
    end
    poke(16'h0100, 32'h80FF_0011);
    run(1'b0, 16'h0103, 2'd0, 1'b1, 32'h0, "byte_load_sext");
    if (SUB) begin
      n_tests++;
      if (bif.cpu_rdata !== 32'hFFFF_FF80) begin
        n_fail++;
        $display("FAIL byte_load_sext_val: got %h required ffffff80", bif.cpu_rdata);
      end
    end
    run(1'b0, 16'h0103, 2'd0, 1'b0, 32'h0, "byte_load_zext");
    if (SUB) begin
      n_tests++;
      if (bif.cpu_rdata !== 32'h0000_0080) begin
        n_fail++;
        $display("FAIL byte_load_zext_val: got %h required 00000080", bif.cpu_rdata);
      end
    end
    poke(16'h0100, 32'h1122_3344);
    run(1'b1, 16'h0101, 2'd0, 1'b0, 32'h0000_005A, "byte_store");
    if (SUB) begin
      n_tests++;
      if (mem[16'h0100 >> 2] !== 32'h1122_5A44) begin
        n_fail++;
        $display("FAIL byte_store_mem: got %h required 11225a44", mem[16'h0100 >> 2]);
      end
    end
    run(1'b0, 16'h0001, 2'd1, 1'b0, 32'h0, "half_misaligned");
    run(1'b1, 16'h0002, 2'd2, 1'b0, 32'hDEAD_BEEF, "word_misaligned");
    run(1'b1, 16'h0000, 2'd3, 1'b0, 32'hDEAD_BEEF, "size_illegal");
    run(1'b0, 16'h0000, 2'd0, 1'b0, 32'h0, "byte_load_a0");
  endtask

  task automatic test_rst_mid_write();
    logic [15:0] a;
    logic        seen;
    a = SUB ? 16'h0101 : 16'h0104;
    @(negedge clk);
    bif.cpu_req = 1'b1;
    bif.cpu_we = 1'b1;
    bif.cpu_addr = a;
    bif.cpu_size = SUB ? 2'd0 : 2'd2;
    bif.cpu_sext = 1'b0;
    bif.cpu_wdata = 32'hCAFE_F00D;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (bif.bus_we) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_wr_reach: bus_we=%b required 1", seen);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (bif.bus_we !== 1'b0 || bif.bus_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_wr_suppress: we=%b wdata=%h required 0 0",
               bif.bus_we, bif.bus_wdata);
    end
    @(posedge clk);
    #1;
    bif.cpu_req = 1'b0;
    n_tests++;
    if ({bif.cpu_busy, bif.cpu_done, bif.cpu_err} !== 3'b0 ||
        bif.bus_adr !== 14'h0 || bif.cpu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_wr_state: busy/done/err=%b%b%b adr=%h rdata=%h required 0",
               bif.cpu_busy, bif.cpu_done, bif.cpu_err, bif.bus_adr, bif.cpu_rdata);
    end
    n_tests++;
    if (mem[a[15:2]] !== ref_mem[a[15:2]]) begin
      n_fail++;
      $display("FAIL rst_wr_mem: got %h required %h", mem[a[15:2]], ref_mem[a[15:2]]);
    end
    rst = 1'b0;
    ref_rdata = '0;
    run(1'b0, a, 2'd2, 1'b0, 32'h0, "after_rst_load");
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      run(1'($urandom), a, sz, 1'($urandom), $urandom, "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run(1'($urandom), 16'(4 * i), 2'd2, 1'b0, $urandom, "b2b");
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    ref_rdata = '0;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_directed();
    test_rst_mid_write();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
